// File: rtl/jpeg_stream_pkg.sv
// Shared register map, status layout, unpacker states and FIFO entry format
// for the JPEG byte-stream output port.
package jpeg_stream_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_BYTE   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;

  // len holds nbytes-1; bytes leave MSB-first starting at word byte[len]
  typedef struct packed {
    logic [1:0]  len;
    logic [31:0] word;
  } entry_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jpeg_stream_fifo.sv
// Synchronous FIFO (module stream_fifo) with head-of-queue combinational read.
// A push while full is dropped even when a pop happens in the same cycle.
module stream_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/jpeg_stream_port.sv
// Memory-mapped JPEG output port: register decode, FIFO and MSB-first byte unpacker.
// Define JPEG_STREAM_STUFF_EN to add CTRL.bit0 and 0x00 insertion after every 0xFF byte.
module jpeg_stream_port
  import jpeg_stream_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 8,
  parameter logic [WIDTH-1:0] BASE  = 32'h0000_1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ramaddress,
  input  logic             writeram,
  input  logic [WIDTH-1:0] writeramdata,
  output logic [WIDTH-1:0] readramdata,
  output logic             hit,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    off;
  logic          wr_en, push, pop, full, empty, overflow, stuff_on;
  logic [CW-1:0] count;
  entry_t        din, head;
  state_t        state;
  logic [31:0]   hold, status;
  logic [1:0]    idx;
  logic          hs, last, stuff_now, adv;
  logic          addr_unused;

  assign off         = ramaddress[3:2];
  assign addr_unused = ^ramaddress[1:0];
  assign hit         = ramaddress[WIDTH-1:4] == BASE[WIDTH-1:4];
  assign wr_en       = hit & writeram;
  assign push        = wr_en & ((off == REG_DATA) | (off == REG_BYTE));

  always_comb begin
    din.len  = (off == REG_DATA) ? 2'd3 : 2'd0;
    din.word = (off == REG_DATA) ? writeramdata : {24'h0, writeramdata[7:0]};
  end

  stream_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Overflow is judged on pre-edge full, so a same-cycle pop never rescues the push
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (push && full)
      overflow <= 1'b1;
    else if (wr_en && off == REG_STATUS && writeramdata[ST_OVF])
      overflow <= 1'b0;
  end

`ifdef JPEG_STREAM_STUFF_EN
  logic stuff_en;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stuff_en <= 1'b0;
    else if (wr_en && off == REG_CTRL)
      stuff_en <= writeramdata[0];
  end
  assign stuff_on = stuff_en;
`else
  assign stuff_on = 1'b0;
`endif

  always_comb begin
    status             = '0;
    status[ST_EMPTY]   = empty;
    status[ST_FULL]    = full;
    status[ST_BUSY]    = ~empty | (state != IDLE);
    status[ST_OVF]     = overflow;
    status[ST_COUNT +: 8] = 8'(count);
  end

  always_comb begin
    readramdata = '0;
    if (hit) begin
      case (off)
        REG_STATUS: readramdata = status;
        REG_CTRL:   readramdata = {31'h0, stuff_on};
        default:    readramdata = '0;
      endcase
    end
  end

  // Stuffing is decided at the FF byte's own handshake, so CTRL changes only
  // affect later FF bytes.
  assign hs        = out_valid & out_ready;
  assign last      = idx == 2'd0;
  assign stuff_now = (state == SEND) & hs & (out_data == 8'hFF) & stuff_on;
  assign adv       = hs & ~stuff_now;
  assign pop       = ~empty & ((state == IDLE) | (adv & last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      state     <= SEND;
      hold      <= head.word;
      idx       <= head.len;
      out_data  <= byte_sel(head.word, head.len);
      out_valid <= 1'b1;
    end else if (stuff_now) begin
      state    <= STUFF;
      out_data <= 8'h00;
    end else if (adv) begin
      if (last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        state    <= SEND;
        idx      <= idx - 2'd1;
        out_data <= byte_sel(hold, idx - 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_jpeg_stream_port.sv
// Directed + randomized bench for jpeg_stream_port; expected streams come from a
// byte-queue model of the register writes. Covers both builds of JPEG_STREAM_STUFF_EN.
module tb_jpeg_stream_port;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_BYTE = BASE + 32'd4;
  localparam logic [31:0] A_STAT = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] ramaddress = '0, writeramdata = '0, readramdata;
  logic        writeram = 1'b0, hit;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        ready_cmd = 1'b0, rand_ready = 1'b0, rnd_bit = 1'b0;

  int          checks = 0, errors = 0, stall_seen = 0, stall_bad = 0;
  logic [7:0]  got[$], exp[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  assign out_ready = rand_ready ? rnd_bit : ready_cmd;

  jpeg_stream_port #(.WIDTH(32), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock        (clock),
    .reset        (reset),
    .ramaddress   (ramaddress),
    .writeram     (writeram),
    .writeramdata (writeramdata),
    .readramdata  (readramdata),
    .hit          (hit),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) rnd_bit = 1'($urandom_range(0, 1));

  // Collect accepted bytes and watch that stalled bytes stay put
  always @(posedge clock) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        stall_seen++;
        if (!(out_valid === 1'b1 && out_data === prev_data)) stall_bad++;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    ramaddress = a; writeramdata = d; writeram = 1'b1;
    @(negedge clock);
    writeram = 1'b0; ramaddress = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ramaddress = a;
    #1;
    d = readramdata;
    ramaddress = '0;
  endtask

  function automatic void model_byte(input logic [7:0] b, input logic s);
    exp.push_back(b);
    if (s && b == 8'hFF) exp.push_back(8'h00);
  endfunction

  task automatic compare_stream(input string tag);
    for (int c = 0; c < 800 && got.size() < exp.size(); c++) @(negedge clock);
    repeat (4) @(negedge clock);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  initial begin
    logic [31:0] d, w;
    logic        stuff, isb;
    int          n;

    repeat (3) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    reset = 1'b0;
    rd(A_STAT, d);
    check("rst_status", d, 32'h1);

    // Window decode
    ramaddress = A_STAT + 32'h10; #1;
    check("miss_hit", hit, 0);
    check("miss_rdata", readramdata, 0);
    ramaddress = A_STAT; #1;
    check("win_hit", hit, 1);
    rd(A_DATA, d); check("rd_data_zero", d, 0);
    rd(A_BYTE, d); check("rd_byte_zero", d, 0);

    // First-byte latency and back-to-back bytes
    ready_cmd = 1'b1;
    wr(A_DATA, 32'h1122_3344);
    check("lat_t", out_valid, 0);
    @(posedge clock); #1;
    check("lat_valid", out_valid, 1);
    check("lat_b0", out_data, 8'h11);
    @(posedge clock); #1; check("lat_b1", out_data, 8'h22);
    @(posedge clock); #1; check("lat_b2", out_data, 8'h33);
    @(posedge clock); #1; check("lat_b3", out_data, 8'h44);
    @(posedge clock); #1; check("lat_done", out_valid, 0);
    rd(A_STAT, d); check("lat_status", d, 32'h1);

    // Backpressure holds the byte stable
    got.delete(); ready_cmd = 1'b0;
    wr(A_BYTE, 32'h1234_56AB);
    wr(A_BYTE, 32'h0000_00CD);
    repeat (5) begin
      @(posedge clock); #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 8'hAB);
    end
    @(negedge clock); ready_cmd = 1'b1;
    exp = '{8'hAB, 8'hCD};
    compare_stream("stall_stream");

    // Overflow: one entry sits in the unpacker, so DEPTH+1 fill everything and the next is dropped
    got.delete(); exp.delete(); ready_cmd = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = $urandom;
      wr(A_DATA, w);
      if (i < DEPTH + 1) for (int k = 3; k >= 0; k--) exp.push_back(w[k*8 +: 8]);
    end
    rd(A_STAT, d); check("ovf_status", d, 32'h0000_080E);
    wr(A_STAT, 32'h8);
    rd(A_STAT, d); check("ovf_clear", d, 32'h0000_0806);
    ready_cmd = 1'b1;
    compare_stream("ovf_stream");
    rd(A_STAT, d); check("ovf_drained", d, 32'h1);

`ifdef JPEG_STREAM_STUFF_EN
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, d); check("ctrl_rd", d, 1);
    got.delete();
    exp = '{8'hFF, 8'h00, 8'h12, 8'hFF, 8'h00, 8'hFF, 8'h00};
    wr(A_DATA, 32'hFF12_FFFF);
    compare_stream("stuff_on");
    wr(A_CTRL, 32'h0);
    got.delete();
    exp = '{8'hFF, 8'h12, 8'hFF, 8'hFF};
    wr(A_DATA, 32'hFF12_FFFF);
    compare_stream("stuff_off");
`else
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, d); check("ctrl_absent", d, 0);
    got.delete();
    exp = '{8'hFF, 8'h12, 8'hFF, 8'hFF};
    wr(A_DATA, 32'hFF12_FFFF);
    compare_stream("raw_ff");
`endif

    // Status with three queued entries behind the one being sent
    got.delete(); exp.delete(); ready_cmd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      wr(A_DATA, w);
      for (int k = 3; k >= 0; k--) exp.push_back(w[k*8 +: 8]);
    end
    rd(A_STAT, d); check("q3_status", d, 32'h0000_0304);
    ready_cmd = 1'b1;
    compare_stream("q3_stream");

    // Reset mid-word after two bytes have been accepted
`ifdef JPEG_STREAM_STUFF_EN
    wr(A_CTRL, 32'h1);
`endif
    got.delete();
    wr(A_DATA, 32'h5566_7788);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1; #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_sent", got.size(), 2);
    repeat (2) @(negedge clock);
    reset = 1'b0; got.delete();
    repeat (6) @(negedge clock);
    check("mrst_silent", got.size(), 0);
    rd(A_STAT, d); check("mrst_status", d, 32'h1);
    rd(A_CTRL, d); check("mrst_ctrl", d, 0);

    // Randomized rounds against the byte-queue model
    for (int r = 0; r < 16; r++) begin
      got.delete(); exp.delete(); stuff = 1'b0;
`ifdef JPEG_STREAM_STUFF_EN
      stuff = 1'($urandom_range(0, 1));
      wr(A_CTRL, {31'h0, stuff});
`endif
      rand_ready = 1'b1;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) w[k*8 +: 8] = 8'hFF;
        isb = 1'($urandom_range(0, 1));
        wr(isb ? A_BYTE : A_DATA, w);
        if (isb) model_byte(w[7:0], stuff);
        else for (int k = 3; k >= 0; k--) model_byte(w[k*8 +: 8], stuff);
      end
      compare_stream("rand");
    end
    rand_ready = 1'b0;
    rd(A_STAT, d); check("rand_status", d, 32'h1);
    check("stall_stable", stall_bad, 0);
    check("stall_exercised", stall_seen > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
